rob_multi: RTL and testbench
============================

Name: rob_multi

Overview:
- Parametrised N-wide reorder buffer: circular queue of DEPTH entries between Dispatch (allocates at tail) and Retire (frees at head).
- Successor to the fixed-width ROB, adding:
  - C completion channels that set per-entry complete bits.
  - Single-cycle branch-mispredict squash (tail rollback).
  - Non-power-of-two DEPTH.
  - Sticky protocol-error flag.

Parameters:
- DEPTH, 32, number of ROB entries (any value ≥ 2N).
- N, 2, superscalar width for dispatch and retire.
- C, 2, number of completion channels.
- PAYLOAD_W, 16, bits per entry payload (T_new, T_old, arch reg packed by the caller).
- IDX_W, $clog2(DEPTH), entry index width (localparam).
- CNT_W, $clog2(DEPTH+1), occupancy width (localparam).
- NSB, $clog2(N+1), scalar count width (localparam).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- disp_entries  in  N*PAYLOAD_W  payloads, slot 0 oldest
- disp_valid  in  NSB  number of valid dispatch slots (always slots 0..disp_valid-1)
- disp_idx  out  N*IDX_W  index allocated to slot i = (tail+i) mod DEPTH
- spots  out  NSB  min(N, DEPTH-num_entries), from registered state only
- cmpl_valid  in  C  per-channel completion strobe
- cmpl_idx  in  C*IDX_W  entry index to mark complete
- ret_entries  out  N*PAYLOAD_W  entries at head+i mod DEPTH
- ret_complete  out  N  complete bit of each ret_entries slot
- ret_valid  out  NSB  min(N, num_entries)
- num_retiring  in  NSB  entries freed this cycle, oldest first
- squash_valid  in  1  mispredict recovery strobe
- squash_idx  in  IDX_W  youngest surviving entry; all younger entries are discarded
- head  out  IDX_W  head pointer
- tail  out  IDX_W  tail pointer
- num_entries  out  CNT_W  occupancy
- err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset=0, async):
  - head=tail=0, num_entries=0, all complete bits 0, err=0.
  - Outputs therefore: spots=N, ret_valid=0, ret_complete=0.
  - Payload storage is not reset.
  - Deassertion is taken synchronously; the first update occurs on the next edge.
- All state updates on the clock edge; outputs are combinational from registers, so results are visible the cycle after the edge.
- Pointer wrap: p+k ≥ DEPTH ⇒ p+k-DEPTH. No reliance on power-of-two masking.
- Full/empty: disambiguated by num_entries only. head==tail with num_entries==DEPTH means full; with num_entries==0 means empty.
- Dispatch:
  - Legal iff disp_valid ≤ min(N, spots+num_retiring). Retire-slot bypass is allowed when full.
  - Writes payload, clears the complete bit, advances tail by disp_valid.
- Retire:
  - Legal iff num_retiring ≤ ret_valid and ret_complete[i]=1 for all i<num_retiring.
  - Advances head by num_retiring; freed complete bits are cleared.
- Completion: each valid channel sets complete[cmpl_idx]. Duplicate indices across channels are allowed (OR).
- Normal cycle: num_entries' = num_entries + disp_valid - num_retiring.
- Squash cycle:
  - Retirement is still applied.
  - Dispatch is ignored (no write, no error check).
  - tail' = squash_idx+1 mod DEPTH.
  - num_entries' = ((squash_idx - head + DEPTH) mod DEPTH) + 1 - num_retiring.
  - Complete bits of discarded entries are cleared.
  - Completions targeting discarded entries that same cycle are dropped.
- squash_idx must be occupied and not among the retiring entries; otherwise err is set and the squash is ignored.
- Any illegal dispatch, retire or squash:
  - Sets err (held until reset).
  - The offending operation is suppressed; other legal operations proceed.
- Completion to an unoccupied index: ignored, sets err.

Decomposition:
- Package rob_multi_pkg: ROB_MULTI_ENTRY payload typedef, index/count typedefs, and a wrap-add function shared with the checker.
- One sub-module, rob_ptr_wrap: combinational modular adder for pointer + count with explicit DEPTH wrap.
- Storage and complete bits stay inline.

Test Plan (DEPTH=6, N=2, C=2):
1. Reset mid-operation: fill 5 entries, drop reset low between edges → immediately num_entries=0, head=tail=0, spots=2, err=0.
2. Wrap: 4 dispatches of 2 with paired retires of 2, each completed first → pointers wrap 4→0; disp_idx sequence 0,1,2,3,4,5,0,1; ret_entries payloads match in order.
3. Full bypass: fill to 6, spots=0. Next cycle, num_retiring=2 (complete) with disp_valid=2 → num_entries stays 6, err=0. disp_valid=1 with num_retiring=0 → err=1, tail unchanged.
4. Squash: head=1, entries at 1..5, squash_idx=3, num_retiring=1 same cycle → head=2, tail=4, num_entries=2. Completion to idx 4 in that cycle is dropped: complete[4]=0.
5. Retire-incomplete: ret_complete=2'b01, num_retiring=2 → err=1, head unchanged.
6. Dual completion same index: cmpl_valid=2'b11, both cmpl_idx=2 → complete[2]=1, err=0.

Source files
------------

// File: rtl/rob_multi_pkg.sv
// Shared types and pointer arithmetic for the multi-wide reorder buffer.
// wrap_add folds p+k back into [0, depth) without assuming a power-of-two depth.
package rob_multi_pkg;

  localparam int ROB_DEPTH_DEF     = 32;
  localparam int ROB_PAYLOAD_W_DEF = 16;
  localparam int ROB_IDX_W_DEF     = $clog2(ROB_DEPTH_DEF);
  localparam int ROB_CNT_W_DEF     = $clog2(ROB_DEPTH_DEF + 1);

  typedef logic [ROB_PAYLOAD_W_DEF-1:0] rob_multi_entry_t;
  typedef logic [ROB_IDX_W_DEF-1:0]     rob_idx_t;
  typedef logic [ROB_CNT_W_DEF-1:0]     rob_cnt_t;

  // Single fold is enough because callers keep p < depth and k <= depth.
  function automatic int wrap_add(int p, int k, int depth);
    return (p + k >= depth) ? p + k - depth : p + k;
  endfunction

endpackage

// File: rtl/rob_ptr_wrap.sv
// Combinational pointer + count adder with an explicit wrap at DEPTH.
module rob_ptr_wrap #(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int INC_W = $clog2(DEPTH + 1)
) (
  input  logic [IDX_W-1:0] ptr,
  input  logic [INC_W-1:0] inc,
  output logic [IDX_W-1:0] sum
);
  import rob_multi_pkg::*;

  assign sum = IDX_W'(wrap_add(int'(ptr), int'(inc), DEPTH));

endmodule

// File: rtl/rob_multi.sv
// N-wide reorder buffer with C completion channels, single-cycle squash and
// a sticky protocol-error flag. Occupancy alone tells full from empty.
module rob_multi #(
  parameter int DEPTH     = 32,
  parameter int N         = 2,
  parameter int C         = 2,
  parameter int PAYLOAD_W = 16,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int NSB      = $clog2(N + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N*PAYLOAD_W-1:0] disp_entries,
  input  logic [NSB-1:0]         disp_valid,
  output logic [N*IDX_W-1:0]     disp_idx,
  output logic [NSB-1:0]         spots,
  input  logic [C-1:0]           cmpl_valid,
  input  logic [C*IDX_W-1:0]     cmpl_idx,
  output logic [N*PAYLOAD_W-1:0] ret_entries,
  output logic [N-1:0]           ret_complete,
  output logic [NSB-1:0]         ret_valid,
  input  logic [NSB-1:0]         num_retiring,
  input  logic                   squash_valid,
  input  logic [IDX_W-1:0]       squash_idx,
  output logic [IDX_W-1:0]       head,
  output logic [IDX_W-1:0]       tail,
  output logic [CNT_W-1:0]       num_entries,
  output logic                   err
);
  import rob_multi_pkg::*;

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     cmp_q, cmp_nx, cmpl_set;
  logic [IDX_W-1:0]     ret_idx [N];
  logic [IDX_W-1:0]     head_nx, tail_nx, tail_disp, sq_tail;
  logic [CNT_W-1:0]     cnt_nx;
  logic [NSB-1:0]       ret_n, disp_n;
  logic                 ret_ok, disp_ok, sq_ok, err_nx;

  assign spots     = (DEPTH - int'(num_entries) >= N) ? NSB'(N) : NSB'(DEPTH - int'(num_entries));
  assign ret_valid = (int'(num_entries) >= N) ? NSB'(N) : NSB'(num_entries);

  for (genvar i = 0; i < N; i++) begin : g_slot
    rob_ptr_wrap #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INC_W(NSB)) u_disp (
      .ptr(tail), .inc(NSB'(i)), .sum(disp_idx[i*IDX_W +: IDX_W]));
    rob_ptr_wrap #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INC_W(NSB)) u_ret (
      .ptr(head), .inc(NSB'(i)), .sum(ret_idx[i]));
    assign ret_entries[i*PAYLOAD_W +: PAYLOAD_W] = mem[ret_idx[i]];
    assign ret_complete[i] = cmp_q[ret_idx[i]];
  end

  rob_ptr_wrap #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INC_W(NSB)) u_head (
    .ptr(head), .inc(ret_n), .sum(head_nx));
  rob_ptr_wrap #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INC_W(NSB)) u_tail (
    .ptr(tail), .inc(disp_n), .sum(tail_disp));
  rob_ptr_wrap #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INC_W(1)) u_sq (
    .ptr(squash_idx), .inc(1'b1), .sum(sq_tail));

  assign tail_nx = sq_ok ? sq_tail : tail_disp;

  always_comb begin
    int sq_d;
    int d;
    d        = 0;
    cmpl_set = '0;

    ret_ok = (num_retiring <= ret_valid);
    for (int i = 0; i < N; i++)
      if (NSB'(i) < num_retiring && !ret_complete[i]) ret_ok = 1'b0;
    ret_n = ret_ok ? num_retiring : '0;

    // Dispatch may reuse slots freed by this cycle's (legal) retirement.
    disp_ok = !squash_valid && int'(disp_valid) <= N &&
              int'(disp_valid) <= int'(spots) + int'(ret_n);
    disp_n  = disp_ok ? disp_valid : '0;

    sq_d  = wrap_add(int'(squash_idx), DEPTH - int'(head), DEPTH);
    sq_ok = squash_valid && int'(squash_idx) < DEPTH &&
            sq_d < int'(num_entries) && sq_d >= int'(ret_n);

    err_nx = err | !ret_ok | (!squash_valid && !disp_ok) | (squash_valid && !sq_ok);

    for (int c = 0; c < C; c++) begin
      d = wrap_add(int'(cmpl_idx[c*IDX_W +: IDX_W]), DEPTH - int'(head), DEPTH);
      if (cmpl_valid[c]) begin
        if (int'(cmpl_idx[c*IDX_W +: IDX_W]) < DEPTH && d < int'(num_entries))
          cmpl_set[cmpl_idx[c*IDX_W +: IDX_W]] = 1'b1;
        else
          err_nx = 1'b1;
      end
    end

    // Freed, discarded and newly allocated entries all leave with a clear bit.
    for (int e = 0; e < DEPTH; e++) begin
      d = wrap_add(e, DEPTH - int'(head), DEPTH);
      cmp_nx[e] = cmp_q[e] | cmpl_set[e];
      if (d < int'(ret_n)) cmp_nx[e] = 1'b0;
      if (sq_ok && d > sq_d && d < int'(num_entries)) cmp_nx[e] = 1'b0;
      if (wrap_add(e, DEPTH - int'(tail), DEPTH) < int'(disp_n)) cmp_nx[e] = 1'b0;
    end

    if (sq_ok) cnt_nx = CNT_W'(sq_d + 1 - int'(ret_n));
    else       cnt_nx = CNT_W'(int'(num_entries) + int'(disp_n) - int'(ret_n));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      num_entries <= '0;
      cmp_q       <= '0;
      err         <= 1'b0;
    end else begin
      head        <= head_nx;
      tail        <= tail_nx;
      num_entries <= cnt_nx;
      cmp_q       <= cmp_nx;
      err         <= err_nx;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++)
      if (NSB'(i) < disp_n)
        mem[disp_idx[i*IDX_W +: IDX_W]] <= disp_entries[i*PAYLOAD_W +: PAYLOAD_W];
  end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi (DEPTH=6, N=2, C=2) against an age-ordered queue model.
module tb_rob_multi;
  localparam int DEPTH = 6;
  localparam int N     = 2;
  localparam int C     = 2;
  localparam int PW    = 16;
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NSB   = $clog2(N + 1);

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N*PW-1:0] disp_entries;
  logic [NSB-1:0]  disp_valid;
  logic [N*IW-1:0] disp_idx;
  logic [NSB-1:0]  spots;
  logic [C-1:0]    cmpl_valid;
  logic [C*IW-1:0] cmpl_idx;
  logic [N*PW-1:0] ret_entries;
  logic [N-1:0]    ret_complete;
  logic [NSB-1:0]  ret_valid;
  logic [NSB-1:0]  num_retiring;
  logic            squash_valid;
  logic [IW-1:0]   squash_idx;
  logic [IW-1:0]   head;
  logic [IW-1:0]   tail;
  logic [CW-1:0]   num_entries;
  logic            err;

  rob_multi #(.DEPTH(DEPTH), .N(N), .C(C), .PAYLOAD_W(PW)) dut (
    .clock(clock), .reset(reset),
    .disp_entries(disp_entries), .disp_valid(disp_valid), .disp_idx(disp_idx),
    .spots(spots), .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
    .ret_entries(ret_entries), .ret_complete(ret_complete), .ret_valid(ret_valid),
    .num_retiring(num_retiring), .squash_valid(squash_valid), .squash_idx(squash_idx),
    .head(head), .tail(tail), .num_entries(num_entries), .err(err));

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;
  int pay_ctr = 'h100;

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: live entries in age order, oldest first.
  typedef struct {
    logic [PW-1:0] pay;
    bit            done;
  } ent_t;
  ent_t mq[$];
  int   m_head = 0;
  bit   m_err  = 1'b0;

  function automatic int occ_pos(int idx);
    int k;
    if (idx >= DEPTH) return -1;
    k = (idx - m_head + DEPTH) % DEPTH;
    return (k < mq.size()) ? k : -1;
  endfunction

  task automatic model_step();
    int n, r, dv, k, lim;
    bit ok;
    ent_t e;
    n  = mq.size();
    r  = int'(num_retiring);
    ok = (r <= min2(N, n));
    for (int i = 0; i < r && ok; i++)
      if (!mq[i].done) ok = 1'b0;
    if (!ok) begin m_err = 1'b1; r = 0; end
    for (int c = 0; c < C; c++) begin
      if (cmpl_valid[c]) begin
        k = occ_pos(int'(cmpl_idx[c*IW +: IW]));
        if (k < 0) m_err = 1'b1;
        else mq[k].done = 1'b1;
      end
    end
    dv = 0;
    if (squash_valid) begin
      k = occ_pos(int'(squash_idx));
      if (k >= r) begin
        while (mq.size() > k + 1) void'(mq.pop_back());
      end else m_err = 1'b1;
    end else begin
      dv  = int'(disp_valid);
      lim = min2(N, DEPTH - n) + r;
      if (dv > N || dv > lim) begin m_err = 1'b1; dv = 0; end
    end
    for (int i = 0; i < r; i++) void'(mq.pop_front());
    m_head = (m_head + r) % DEPTH;
    for (int i = 0; i < dv; i++) begin
      e.pay  = disp_entries[i*PW +: PW];
      e.done = 1'b0;
      mq.push_back(e);
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_head = 0;
      m_err  = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clock) begin : cmp_proc
    int n;
    int t;
    if (started) begin
      n = mq.size();
      t = (m_head + n) % DEPTH;
      chk("num_entries", 32'(num_entries), n);
      chk("head", 32'(head), m_head);
      chk("tail", 32'(tail), t);
      chk("spots", 32'(spots), min2(N, DEPTH - n));
      chk("ret_valid", 32'(ret_valid), min2(N, n));
      chk("err", 32'(err), 32'(m_err));
      for (int i = 0; i < N; i++) begin
        chk("disp_idx", 32'(disp_idx[i*IW +: IW]), (t + i) % DEPTH);
        if (i < n) begin
          chk("ret_complete", 32'(ret_complete[i]), 32'(mq[i].done));
          chk("ret_entries", 32'(ret_entries[i*PW +: PW]), 32'(mq[i].pay));
        end else begin
          chk("ret_complete_free", 32'(ret_complete[i]), 0);
        end
      end
    end
  end

  task automatic set_in(int dv, int nr, int cv, int ci0, int ci1, int sv, int si);
    disp_valid   = NSB'(dv);
    num_retiring = NSB'(nr);
    cmpl_valid   = C'(cv);
    cmpl_idx     = {IW'(ci1), IW'(ci0)};
    squash_valid = (sv != 0);
    squash_idx   = IW'(si);
    for (int i = 0; i < N; i++) disp_entries[i*PW +: PW] = PW'(pay_ctr + i);
    if (dv > 0) pay_ctr += N;
  endtask

  task automatic drive(int dv, int nr, int cv, int ci0, int ci1, int sv, int si);
    set_in(dv, nr, cv, ci0, ci1, sv, si);
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_num_entries", 32'(num_entries), 0);
    chk("rst_head", 32'(head), 0);
    chk("rst_tail", 32'(tail), 0);
    chk("rst_spots", 32'(spots), 2);
    chk("rst_err", 32'(err), 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset   = 1'b1;
    started = 1'b1;
    chk("init_spots", 32'(spots), 2);
    chk("init_ret_valid", 32'(ret_valid), 0);
    chk("init_ret_complete", 32'(ret_complete), 0);
    chk("init_disp_idx", 32'(disp_idx), 32'h08);

    // Fill 5, illegal over-dispatch, then asynchronous reset mid-operation.
    drive(2, 0, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("fill5_num", 32'(num_entries), 5);
    chk("fill5_spots", 32'(spots), 1);
    drive(2, 0, 0, 0, 0, 0, 0);
    chk("overfill_err", 32'(err), 1);
    chk("overfill_tail", 32'(tail), 5);
    pulse_reset();

    // Wrap-around with paired dispatch/retire.
    drive(2, 0, 0, 0, 0, 0, 0);
    chk("wrap_ret_pay", 32'(ret_entries), 32'h0109_0108);
    drive(2, 0, 3, 0, 1, 0, 0);
    chk("wrap_disp_idx45", 32'(disp_idx), 32'(5 * 8 + 4));
    drive(2, 2, 3, 2, 3, 0, 0);
    chk("wrap_tail0", 32'(tail), 0);
    chk("wrap_head2", 32'(head), 2);
    chk("wrap_ret_pay2", 32'(ret_entries), 32'h010b_010a);
    chk("wrap_disp_idx01", 32'(disp_idx), 32'h08);
    drive(2, 2, 3, 4, 5, 0, 0);
    chk("wrap_head4", 32'(head), 4);
    drive(0, 2, 3, 0, 1, 0, 0);
    chk("wrap_head0", 32'(head), 0);
    chk("wrap_ret_pay3", 32'(ret_entries), 32'h010f_010e);
    drive(0, 2, 0, 0, 0, 0, 0);
    chk("wrap_empty", 32'(num_entries), 0);

    // Full with retire-slot bypass, then illegal dispatch while full.
    drive(2, 0, 0, 0, 0, 0, 0);
    drive(2, 0, 3, 2, 3, 0, 0);
    drive(2, 0, 0, 0, 0, 0, 0);
    chk("full_num", 32'(num_entries), 6);
    chk("full_spots", 32'(spots), 0);
    drive(2, 2, 0, 0, 0, 0, 0);
    chk("bypass_num", 32'(num_entries), 6);
    chk("bypass_err", 32'(err), 0);
    chk("bypass_head", 32'(head), 4);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("full_disp_err", 32'(err), 1);
    chk("full_disp_tail", 32'(tail), 4);
    pulse_reset();

    // Squash with same-cycle retire and a dropped completion.
    drive(2, 0, 0, 0, 0, 0, 0);
    drive(2, 0, 1, 0, 0, 0, 0);
    drive(2, 1, 1, 1, 0, 0, 0);
    chk("presq_head", 32'(head), 1);
    chk("presq_num", 32'(num_entries), 5);
    drive(0, 1, 1, 4, 0, 1, 3);
    chk("sq_head", 32'(head), 2);
    chk("sq_tail", 32'(tail), 4);
    chk("sq_num", 32'(num_entries), 2);
    chk("sq_err", 32'(err), 0);
    // Both channels complete index 2.
    drive(0, 0, 3, 2, 2, 0, 0);
    chk("dual_cmpl", 32'(ret_complete), 32'b01);
    chk("dual_err", 32'(err), 0);
    drive(0, 2, 0, 0, 0, 0, 0);
    chk("ret_incmpl_err", 32'(err), 1);
    chk("ret_incmpl_head", 32'(head), 2);
    drive(0, 0, 1, 3, 0, 0, 0);
    chk("cmpl3", 32'(ret_complete), 32'b11);
    drive(0, 2, 0, 0, 0, 0, 0);
    chk("dropped_cmpl4", 32'(ret_complete), 32'b00);
    chk("post_sq_head", 32'(head), 4);

    // Completion to an empty buffer, then a squash to an unoccupied index.
    pulse_reset();
    drive(0, 0, 1, 3, 0, 0, 0);
    chk("cmpl_unocc_err", 32'(err), 1);
    pulse_reset();
    drive(2, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 4);
    chk("bad_sq_err", 32'(err), 1);
    chk("bad_sq_tail", 32'(tail), 2);
    chk("bad_sq_num", 32'(num_entries), 2);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
